// File: rtl/sw_pkt_tx.sv
// Switch ingress transmitter: buffers one host packet, waits for all ports ready,
// then streams DA, SA, LEN and payload contiguously on sw_en/sw_data.
module sw_pkt_tx #(
  parameter int unsigned NUM_OF_PORTS = 4,
  parameter int unsigned W_WIDTH      = 8,
  parameter int unsigned PKT_DEPTH    = 64,
  parameter int unsigned IFG          = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    host_start,
  input  logic [W_WIDTH-1:0]      host_da,
  input  logic [W_WIDTH-1:0]      host_sa,
  input  logic [W_WIDTH-1:0]      host_len,
  input  logic                    host_wr,
  input  logic [W_WIDTH-1:0]      host_wdata,
  output logic                    host_busy,
  output logic                    host_err,
  input  logic [NUM_OF_PORTS-1:0] ports_rd,
  output logic                    sw_en,
  output logic [W_WIDTH-1:0]      sw_data,
  output logic                    tx_done,
  output logic [15:0]             pkt_cnt
);

  // Length counters must hold PKT_DEPTH itself, not just PKT_DEPTH-1.
  localparam int unsigned LW = $clog2(PKT_DEPTH + 1);
  localparam int unsigned AW = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
  localparam int unsigned GW = $clog2(IFG + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_HDR,
    S_PLD,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [W_WIDTH-1:0]   da_q, da_d;
  logic [W_WIDTH-1:0]   sa_q, sa_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]        snd_q, snd_d;
  logic [1:0]           hdr_q, hdr_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 host_busy_q, host_busy_d;
  logic                 host_err_q, host_err_d;
  logic                 sw_en_q, sw_en_d;
  logic [W_WIDTH-1:0]   sw_data_q, sw_data_d;
  logic                 tx_done_q, tx_done_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;

  logic [W_WIDTH-1:0]   mem [PKT_DEPTH];
  logic                 mem_we_c;
  logic                 pld_word_c;
  logic                 len_ok_c;
  logic [LW-1:0]        snd_nxt_c;
  logic [LW-1:0]        wr_nxt_c;

  assign len_ok_c  = (host_len != '0) && (32'(host_len) <= PKT_DEPTH);
  assign snd_nxt_c = LW'(snd_q + LW'(1));
  assign wr_nxt_c  = LW'(wr_ptr_q + LW'(1));
  assign mem_we_c  = (state_q == S_LOAD) && host_wr;

  // Payload buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[wr_ptr_q[AW-1:0]] <= host_wdata;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    da_d        = da_q;
    sa_d        = sa_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    snd_d       = snd_q;
    hdr_d       = hdr_q;
    gap_d       = gap_q;
    pkt_cnt_d   = pkt_cnt_q;
    host_err_d  = 1'b0;
    sw_en_d     = 1'b0;
    sw_data_d   = '0;
    tx_done_d   = 1'b0;
    pld_word_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host_start) begin
          if (len_ok_c) begin
            da_d     = host_da;
            sa_d     = host_sa;
            len_d    = LW'(host_len);
            wr_ptr_d = '0;
            snd_d    = '0;
            hdr_d    = '0;
            state_d  = S_LOAD;
          end else begin
            host_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (host_wr) begin
          wr_ptr_d = wr_nxt_c;
          if (wr_nxt_c == len_q) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (&ports_rd) begin
          sw_en_d   = 1'b1;
          sw_data_d = da_q;
          hdr_d     = '0;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        // hdr_q tracks which header byte is currently on the bus.
        if (hdr_q == 2'd0) begin
          sw_en_d   = 1'b1;
          sw_data_d = sa_q;
          hdr_d     = 2'd1;
        end else if (hdr_q == 2'd1) begin
          sw_en_d   = 1'b1;
          sw_data_d = W_WIDTH'(len_q);
          hdr_d     = 2'd2;
        end else begin
          pld_word_c = 1'b1;
          state_d    = S_PLD;
        end
      end
      S_PLD: begin
        if (snd_q == len_q) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          pld_word_c = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(IFG - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = GW'(gap_q + GW'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Payload word snd_q goes on the bus; the last one carries tx_done.
    if (pld_word_c) begin
      sw_en_d   = 1'b1;
      sw_data_d = mem[snd_q[AW-1:0]];
      snd_d     = snd_nxt_c;
      if (snd_nxt_c == len_q) begin
        tx_done_d = 1'b1;
        pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
    end

    host_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      da_q        <= '0;
      sa_q        <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      snd_q       <= '0;
      hdr_q       <= '0;
      gap_q       <= '0;
      host_busy_q <= 1'b0;
      host_err_q  <= 1'b0;
      sw_en_q     <= 1'b0;
      sw_data_q   <= '0;
      tx_done_q   <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      da_q        <= da_d;
      sa_q        <= sa_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      snd_q       <= snd_d;
      hdr_q       <= hdr_d;
      gap_q       <= gap_d;
      host_busy_q <= host_busy_d;
      host_err_q  <= host_err_d;
      sw_en_q     <= sw_en_d;
      sw_data_q   <= sw_data_d;
      tx_done_q   <= tx_done_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign host_busy = host_busy_q;
  assign host_err  = host_err_q;
  assign sw_en     = sw_en_q;
  assign sw_data   = sw_data_q;
  assign tx_done   = tx_done_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_sw_pkt_tx.sv
// Directed bench for sw_pkt_tx: framing, backpressure, error strobes, limits, async reset.
module tb_sw_pkt_tx;

  logic        clk;
  logic        rst_n;
  logic        host_start;
  logic [7:0]  host_da;
  logic [7:0]  host_sa;
  logic [7:0]  host_len;
  logic        host_wr;
  logic [7:0]  host_wdata;
  logic        host_busy;
  logic        host_err;
  logic [3:0]  ports_rd;
  logic        sw_en;
  logic [7:0]  sw_data;
  logic        tx_done;
  logic [15:0] pkt_cnt;

  int errors;
  int checks;
  logic [7:0] pl [64];

  sw_pkt_tx #(
    .NUM_OF_PORTS(4),
    .W_WIDTH     (8),
    .PKT_DEPTH   (64),
    .IFG         (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host_start(host_start),
    .host_da   (host_da),
    .host_sa   (host_sa),
    .host_len  (host_len),
    .host_wr   (host_wr),
    .host_wdata(host_wdata),
    .host_busy (host_busy),
    .host_err  (host_err),
    .ports_rd  (ports_rd),
    .sw_en     (sw_en),
    .sw_data   (sw_data),
    .tx_done   (tx_done),
    .pkt_cnt   (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a packet and write pl[0..len-1]; returns on the negedge where state is WAIT.
  task automatic load(input logic [7:0] da, input logic [7:0] sa, input int len);
    @(negedge clk);
    host_start = 1'b1;
    host_da    = da;
    host_sa    = sa;
    host_len   = 8'(len);
    @(negedge clk);
    host_start = 1'b0;
    chk("load_busy", 32'(host_busy), 32'd1);
    for (int i = 0; i < len; i++) begin
      host_wr    = 1'b1;
      host_wdata = pl[i];
      @(negedge clk);
    end
    host_wr = 1'b0;
  endtask

  // Wait (bounded) for sw_en, then check every byte of the frame and the trailing idle.
  task automatic expect_frame(input string tag, input logic [7:0] da, input logic [7:0] sa,
                              input int len, input bit drop_mid);
    int n;
    logic [7:0] exp_b;
    n = 0;
    while (!sw_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, 32'(sw_en), 32'd1);
    for (int i = 0; i < 3 + len; i++) begin
      if (i == 0)      exp_b = da;
      else if (i == 1) exp_b = sa;
      else if (i == 2) exp_b = 8'(len);
      else             exp_b = pl[i-3];
      chk({tag, "_sw_en"}, 32'(sw_en), 32'd1);
      chk({tag, "_data"}, 32'(sw_data), 32'(exp_b));
      chk({tag, "_tx_done"}, 32'(tx_done), (i == len + 2) ? 32'd1 : 32'd0);
      if (drop_mid && i == 4) ports_rd = 4'h0;
      @(negedge clk);
    end
    chk({tag, "_end_sw_en"}, 32'(sw_en), 32'd0);
    chk({tag, "_end_data"}, 32'(sw_data), 32'd0);
    chk({tag, "_end_tx_done"}, 32'(tx_done), 32'd0);
    ports_rd = 4'hF;
  endtask

  initial begin
    int n;
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b1;
    host_start = 1'b0;
    host_da    = '0;
    host_sa    = '0;
    host_len   = '0;
    host_wr    = 1'b0;
    host_wdata = '0;
    ports_rd   = 4'hF;

    // Power-on reset
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(host_busy), 32'd0);
    chk("rst_err", 32'(host_err), 32'd0);
    chk("rst_sw_en", 32'(sw_en), 32'd0);
    chk("rst_data", 32'(sw_data), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_cnt", 32'(pkt_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic packet
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
    load(8'h01, 8'h55, 3);
    expect_frame("basic", 8'h01, 8'h55, 3, 1'b0);
    chk("basic_cnt", 32'(pkt_cnt), 32'd1);

    // Wait for busy to drop before the next start
    n = 0;
    while (host_busy && n < 20) begin @(negedge clk); n++; end
    chk("basic_idle", 32'(host_busy), 32'd0);

    // Backpressure: one port full for 10 cycles
    ports_rd = 4'hB;
    pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30;
    load(8'h02, 8'h66, 3);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_sw_en", 32'(sw_en), 32'd0);
      chk("bp_hold_busy", 32'(host_busy), 32'd1);
      @(negedge clk);
    end
    ports_rd = 4'hF;
    @(negedge clk);
    chk("bp_da_latency", 32'(sw_en), 32'd1);
    chk("bp_da_value", 32'(sw_data), 32'h02);
    expect_frame("bp", 8'h02, 8'h66, 3, 1'b1);
    chk("bp_cnt", 32'(pkt_cnt), 32'd2);
    n = 0;
    while (host_busy && n < 20) begin @(negedge clk); n++; end

    // Illegal lengths
    host_start = 1'b1; host_len = 8'd0;
    @(negedge clk);
    host_start = 1'b0;
    chk("err_len0_pulse", 32'(host_err), 32'd1);
    chk("err_len0_busy", 32'(host_busy), 32'd0);
    @(negedge clk);
    chk("err_len0_clear", 32'(host_err), 32'd0);
    host_start = 1'b1; host_len = 8'd65;
    @(negedge clk);
    host_start = 1'b0;
    chk("err_len65_pulse", 32'(host_err), 32'd1);
    chk("err_len65_busy", 32'(host_busy), 32'd0);
    @(negedge clk);
    chk("err_len65_clear", 32'(host_err), 32'd0);

    // host_start during LOAD is ignored
    pl[0] = 8'h5A; pl[1] = 8'hA5;
    host_start = 1'b1; host_da = 8'h11; host_sa = 8'h22; host_len = 8'd2;
    @(negedge clk);
    host_start = 1'b0;
    host_wr = 1'b1; host_wdata = pl[0];
    @(negedge clk);
    host_wr = 1'b0;
    host_start = 1'b1; host_da = 8'h99; host_sa = 8'h88; host_len = 8'd5;
    @(negedge clk);
    host_start = 1'b0;
    chk("busy_start_no_err", 32'(host_err), 32'd0);
    host_wr = 1'b1; host_wdata = pl[1];
    @(negedge clk);
    host_wr = 1'b0;
    expect_frame("ignore", 8'h11, 8'h22, 2, 1'b0);
    chk("ignore_cnt", 32'(pkt_cnt), 32'd3);
    n = 0;
    while (host_busy && n < 20) begin @(negedge clk); n++; end

    // Asynchronous reset in the middle of the payload
    for (int i = 0; i < 6; i++) pl[i] = 8'(8'hC0 + i);
    load(8'h03, 8'h77, 6);
    n = 0;
    while (!sw_en && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    chk("mid_pld_before", 32'(sw_data), 32'hC1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sw_en", 32'(sw_en), 32'd0);
    chk("arst_data", 32'(sw_data), 32'd0);
    chk("arst_cnt", 32'(pkt_cnt), 32'd0);
    chk("arst_busy", 32'(host_busy), 32'd0);
    chk("arst_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_after_sw_en", 32'(sw_en), 32'd0);

    // Limits: LEN=1 then LEN=64
    pl[0] = 8'h7E;
    load(8'h04, 8'h88, 1);
    expect_frame("len1", 8'h04, 8'h88, 1, 1'b0);
    n = 0;
    while (host_busy && n < 20) begin
      chk("gap_sw_en", 32'(sw_en), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("gap_cycles", 32'(n), 32'd2);
    for (int i = 0; i < 64; i++) pl[i] = 8'(i * 3 + 7);
    load(8'h08, 8'h99, 64);
    expect_frame("len64", 8'h08, 8'h99, 64, 1'b0);
    chk("limits_cnt", 32'(pkt_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
